// File: rtl/seq_shift_add_multiplier_if.sv
// rtl/seq_shift_add_multiplier_if.sv - operand/result handshake bundle for seq_shift_add_multiplier
interface seq_shift_add_multiplier_if #(
    parameter int N = 8
);
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   multiplicand;
    logic [N-1:0]   multiplier;
    logic           signed_op;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] product;

    modport master (
        output in_valid, multiplicand, multiplier, signed_op, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, multiplicand, multiplier, signed_op, out_ready,
        output in_ready, out_valid, product
    );
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// rtl/seq_shift_add_multiplier.sv - radix-2 shift-add N x N multiplier, one multiplier bit per cycle
// Optional two's complement mode is built only when SIGNED_MODE_EN is defined.
module seq_shift_add_multiplier #(
    parameter int N = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    seq_shift_add_multiplier_if.slave  bus
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [N-1:0]    r_a;
    logic [N-1:0]    r_hi;
    logic [N-1:0]    r_lo;
    logic [CW-1:0]   r_cnt;
    logic [2*N-1:0]  r_product;
    logic            w_last;
    logic            w_sub;
    logic [N:0]      w_hi_ext;
    logic [N:0]      w_a_ext;
    logic [N:0]      w_sum;

    assign w_last = (r_cnt == CW'(N - 1));

`ifdef SIGNED_MODE_EN
    logic r_signed;
    assign w_hi_ext = {r_signed & r_hi[N-1], r_hi};
    assign w_a_ext  = {r_signed & r_a[N-1], r_a};
    // The multiplier MSB carries negative weight in two's complement.
    assign w_sub    = r_signed & w_last;
`else
    logic w_unused_signed;
    assign w_unused_signed = bus.signed_op;
    assign w_hi_ext = {1'b0, r_hi};
    assign w_a_ext  = {1'b0, r_a};
    assign w_sub    = 1'b0;
`endif

    always_comb begin
        w_sum = w_hi_ext;
        if (r_lo[0]) begin
            w_sum = w_sub ? (w_hi_ext - w_a_ext) : (w_hi_ext + w_a_ext);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid)  w_next = S_CALC;
            S_CALC:  if (w_last)        w_next = S_DONE;
            S_DONE:  if (bus.out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (r_state == S_IDLE);
        bus.out_valid = (r_state == S_DONE);
    end

    assign bus.product = r_product;

    // r_lo starts as the multiplier and fills with product low bits as it shifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_cnt     <= '0;
            r_product <= '0;
`ifdef SIGNED_MODE_EN
            r_signed  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a      <= bus.multiplicand;
                        r_hi     <= '0;
                        r_lo     <= bus.multiplier;
                        r_cnt    <= '0;
`ifdef SIGNED_MODE_EN
                        r_signed <= bus.signed_op;
`endif
                    end
                end
                S_CALC: begin
                    r_hi  <= w_sum[N:1];
                    r_lo  <= {w_sum[0], r_lo[N-1:1]};
                    r_cnt <= w_last ? '0 : r_cnt + CW'(1);
                    if (w_last) begin
                        r_product <= {w_sum[N:1], w_sum[0], r_lo[N-1:1]};
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// tb/tb_seq_shift_add_multiplier.sv - self-checking bench for seq_shift_add_multiplier (N=4 and N=8 instances)
module tb_seq_shift_add_multiplier;
    localparam int NA = 4;
    localparam int NB = 8;
`ifdef SIGNED_MODE_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic        drv_iv [2];
    logic [7:0]  drv_a  [2];
    logic [7:0]  drv_b  [2];
    logic        drv_s  [2];
    logic        drv_or [2];
    logic        dut_ir [2];
    logic        dut_ov [2];
    logic [15:0] dut_p  [2];

    seq_shift_add_multiplier_if #(.N(NA)) bus_a ();
    seq_shift_add_multiplier_if #(.N(NB)) bus_b ();

    seq_shift_add_multiplier #(.N(NA)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    seq_shift_add_multiplier #(.N(NB)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    assign bus_a.in_valid     = drv_iv[0];
    assign bus_a.multiplicand = drv_a[0][3:0];
    assign bus_a.multiplier   = drv_b[0][3:0];
    assign bus_a.signed_op    = drv_s[0];
    assign bus_a.out_ready    = drv_or[0];
    assign bus_b.in_valid     = drv_iv[1];
    assign bus_b.multiplicand = drv_a[1];
    assign bus_b.multiplier   = drv_b[1];
    assign bus_b.signed_op    = drv_s[1];
    assign bus_b.out_ready    = drv_or[1];
    assign dut_ir[0] = bus_a.in_ready;
    assign dut_ov[0] = bus_a.out_valid;
    assign dut_p[0]  = {8'h00, bus_a.product};
    assign dut_ir[1] = bus_b.in_ready;
    assign dut_ov[1] = bus_b.out_valid;
    assign dut_p[1]  = bus_b.product;

    function automatic int wid(int i);
        return (i == 0) ? NA : NB;
    endfunction

    // Exact product from plain integer arithmetic, truncated to 2n bits.
    function automatic logic [15:0] ref_mul(int n, logic [7:0] a, logic [7:0] b, logic s);
        longint sa;
        longint sb;
        longint mask;
        mask = (longint'(1) << n) - 1;
        sa = longint'(a) & mask;
        sb = longint'(b) & mask;
        if (s && SIGNED_EN) begin
            if (sa >= (longint'(1) << (n - 1))) sa = sa - (longint'(1) << n);
            if (sb >= (longint'(1) << (n - 1))) sb = sb - (longint'(1) << n);
        end
        return 16'((sa * sb) & ((longint'(1) << (2 * n)) - 1));
    endfunction

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-level reference: 0 idle, 1 computing (countdown of N cycles), 2 result held.
    int          m_phase   [2] = '{0, 0};
    int          m_wait    [2] = '{0, 0};
    int          m_results [2] = '{0, 0};
    logic [15:0] m_exp     [2] = '{16'h0, 16'h0};
    logic [15:0] m_prod    [2] = '{16'h0, 16'h0};

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_phase[i] = 0;
                m_wait[i]  = 0;
                m_prod[i]  = 16'h0;
            end else if (m_phase[i] == 0) begin
                if (drv_iv[i]) begin
                    m_exp[i]   = ref_mul(wid(i), drv_a[i], drv_b[i], drv_s[i]);
                    m_wait[i]  = wid(i);
                    m_phase[i] = 1;
                end
            end else if (m_phase[i] == 1) begin
                m_wait[i]--;
                if (m_wait[i] == 0) begin
                    m_phase[i] = 2;
                    m_prod[i]  = m_exp[i];
                end
            end else if (drv_or[i]) begin
                m_phase[i] = 0;
                m_results[i]++;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check($sformatf("in_ready[%0d]", i), 16'(dut_ir[i]), 16'(m_phase[i] == 0));
            check($sformatf("out_valid[%0d]", i), 16'(dut_ov[i]), 16'(m_phase[i] == 2));
            check($sformatf("product[%0d]", i), dut_p[i], m_prod[i]);
        end
    end

    task automatic do_op(int i, logic [7:0] a, logic [7:0] b, logic s, int hold,
                         bit perturb, bit poke, output logic [15:0] got);
        int t;
        drv_a[i]  = a;
        drv_b[i]  = b;
        drv_s[i]  = s;
        drv_iv[i] = 1'b1;
        drv_or[i] = 1'b0;
        t = 0;
        while (!dut_ir[i] && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!dut_ir[i]) begin
            n_vec++; n_err++;
            $display("FAIL accept_timeout[%0d]: in_ready 0, required 1", i);
        end
        @(posedge clk); #1;
        drv_iv[i] = 1'b0;
        t = 0;
        while (!dut_ov[i] && t < 50) begin
            if (perturb) begin
                drv_a[i] = 8'($urandom);
                drv_b[i] = 8'($urandom);
                drv_s[i] = 1'($urandom);
            end
            @(posedge clk); #1;
            t++;
        end
        if (!dut_ov[i]) begin
            n_vec++; n_err++;
            $display("FAIL result_timeout[%0d]: out_valid 0, required 1", i);
        end
        got = dut_p[i];
        for (int k = 0; k < hold; k++) begin
            drv_iv[i] = poke && (k == 3);
            @(posedge clk); #1;
        end
        drv_iv[i] = 1'b0;
        drv_or[i] = 1'b1;
        @(posedge clk); #1;
        drv_or[i] = 1'b0;
    endtask

    initial begin
        logic [15:0] got;
        int start;
        int t;
        for (int i = 0; i < 2; i++) begin
            drv_iv[i] = 1'b0; drv_a[i] = 8'h0; drv_b[i] = 8'h0;
            drv_s[i]  = 1'b0; drv_or[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 16'(dut_ir[1]), 16'h1);
        check("reset_out_valid", 16'(dut_ov[1]), 16'h0);
        check("reset_product", dut_p[1], 16'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(0, 8'd15, 8'd15, 1'b0, 0, 1'b0, 1'b0, got);
        check("n4_15x15", got, 16'h00E1);
        do_op(0, 8'd0, 8'd9, 1'b0, 0, 1'b0, 1'b0, got);
        check("n4_0x9", got, 16'h0000);
        do_op(0, 8'h08, 8'h08, 1'b1, 0, 1'b0, 1'b0, got);
        check("n4_s_8x8", got, 16'h0040);
        do_op(0, 8'h08, 8'h07, 1'b1, 0, 1'b1, 1'b0, got);
        check("n4_s_8x7", got, SIGNED_EN ? 16'h00C8 : 16'h0038);

        do_op(1, 8'd255, 8'd255, 1'b0, 10, 1'b0, 1'b1, got);
        check("n8_bp_255x255", got, 16'hFE01);
        do_op(1, 8'h80, 8'h80, 1'b1, 0, 1'b1, 1'b0, got);
        check("n8_s_min_sq", got, 16'h4000);
        do_op(1, 8'h80, 8'h7F, 1'b1, 3, 1'b1, 1'b0, got);
        check("n8_s_min_x_max", got, SIGNED_EN ? 16'hC080 : 16'h3F80);

        drv_a[1] = 8'd77; drv_b[1] = 8'd91; drv_s[1] = 1'b0; drv_iv[1] = 1'b1;
        @(posedge clk); #1;
        drv_iv[1] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midcalc_rst_out_valid", 16'(dut_ov[1]), 16'h0);
        check("midcalc_rst_product", dut_p[1], 16'h0);
        check("midcalc_rst_in_ready", 16'(dut_ir[1]), 16'h1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_op(1, 8'd200, 8'd3, 1'b0, 0, 1'b0, 1'b0, got);
        check("after_rst_200x3", got, 16'd600);

        start = m_results[1];
        drv_iv[1] = 1'b1;
        drv_or[1] = 1'b1;
        t = 0;
        while ((m_results[1] - start) < 100 && t < 3000) begin
            drv_a[1] = 8'($urandom);
            drv_b[1] = 8'($urandom);
            drv_s[1] = 1'($urandom);
            @(posedge clk); #1;
            t++;
        end
        drv_iv[1] = 1'b0;
        check("stream_results", 16'(m_results[1] - start), 16'd100);
        repeat (NB + 4) @(posedge clk);
        #1;
        drv_or[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
